// File: rtl/pipe_ctrl_hazard.sv
// Pipeline control unit for a 5-stage MIPS32 core.
// - Decodes the ID-stage instruction.
// - Carries E/M/W control bits.
// - Detects RAW hazards and drives the forwarding selects.
// - Inserts load-use stalls and counts stall cycles.
// Optional feature: define PIPE_FWD_EN to enable operand forwarding. When it is
// undefined, every RAW hazard stalls until the writer reaches WB.
module pipe_ctrl_hazard #(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [31:0]      inst,
    input  logic             rsrtequ,
    output logic             wpcir,
    output logic [1:0]       pcsource,
    output logic             regrt,
    output logic             sext,
    output logic             aluimm_d,
    output logic             shift_d,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic             ealuimm,
    output logic             eshift,
    output logic             ejal,
    output logic [3:0]       ealuc,
    output logic [RA_W-1:0]  ern,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [RA_W-1:0]  mrn,
    output logic             wwreg,
    output logic             wm2reg,
    output logic [RA_W-1:0]  wrn,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic            wmem;
        logic            aluimm;
        logic            shift;
        logic            jal;
        logic [3:0]      aluc;
        logic [RA_W-1:0] rn;
    } ectl_t;

    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic            wmem;
        logic [RA_W-1:0] rn;
    } mctl_t;

    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic [RA_W-1:0] rn;
    } wctl_t;

    logic [5:0]      op, fn;
    logic [RA_W-1:0] rs, rt, rd;
    ectl_t           dec, e_d, e_q;
    mctl_t           m_d, m_q;
    wctl_t           w_d, w_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic            use_rs, use_rt, is_beq, is_bne, is_jr, is_j;
    logic            e_hit, stall;
    logic            unused_shamt;

    assign op = inst[31:26];
    assign fn = inst[5:0];
    assign rs = RA_W'(inst[25:21]);
    assign rt = RA_W'(inst[20:16]);
    assign rd = RA_W'(inst[15:11]);
    // Shift amount is consumed by the datapath, not by control.
    assign unused_shamt = ^inst[10:6];

    // ID-stage decode; unknown encodings fall through as a NOP.
    always_comb begin
        dec    = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        regrt  = 1'b0;
        sext   = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_jr  = 1'b0;
        is_j   = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: begin dec.wreg = 1'b1; dec.aluc = 4'b0000; use_rs = 1'b1; use_rt = 1'b1; end
                    6'h22: begin dec.wreg = 1'b1; dec.aluc = 4'b0100; use_rs = 1'b1; use_rt = 1'b1; end
                    6'h24: begin dec.wreg = 1'b1; dec.aluc = 4'b0001; use_rs = 1'b1; use_rt = 1'b1; end
                    6'h25: begin dec.wreg = 1'b1; dec.aluc = 4'b0101; use_rs = 1'b1; use_rt = 1'b1; end
                    6'h26: begin dec.wreg = 1'b1; dec.aluc = 4'b0010; use_rs = 1'b1; use_rt = 1'b1; end
                    6'h2a: begin dec.wreg = 1'b1; dec.aluc = 4'b1000; use_rs = 1'b1; use_rt = 1'b1; end
                    6'h00: begin dec.wreg = 1'b1; dec.aluc = 4'b0011; dec.shift = 1'b1; use_rt = 1'b1; end
                    6'h02: begin dec.wreg = 1'b1; dec.aluc = 4'b0111; dec.shift = 1'b1; use_rt = 1'b1; end
                    6'h03: begin dec.wreg = 1'b1; dec.aluc = 4'b1111; dec.shift = 1'b1; use_rt = 1'b1; end
                    6'h08: begin is_jr = 1'b1; use_rs = 1'b1; end
                    default: ;
                endcase
            end
            6'h08: begin dec.wreg = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; sext = 1'b1; use_rs = 1'b1; end
            6'h0c: begin dec.wreg = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; dec.aluc = 4'b0001; use_rs = 1'b1; end
            6'h0d: begin dec.wreg = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; dec.aluc = 4'b0101; use_rs = 1'b1; end
            6'h0e: begin dec.wreg = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; dec.aluc = 4'b0010; use_rs = 1'b1; end
            6'h23: begin
                dec.wreg = 1'b1; dec.m2reg = 1'b1; dec.aluimm = 1'b1;
                regrt = 1'b1; sext = 1'b1; use_rs = 1'b1;
            end
            6'h2b: begin dec.wmem = 1'b1; dec.aluimm = 1'b1; sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h04: begin is_beq = 1'b1; dec.aluc = 4'b0010; sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h05: begin is_bne = 1'b1; dec.aluc = 4'b0010; sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h0f: begin dec.wreg = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; dec.aluc = 4'b0110; end
            6'h02: is_j = 1'b1;
            6'h03: begin is_j = 1'b1; dec.wreg = 1'b1; dec.jal = 1'b1; end
            default: ;
        endcase
        dec.rn = dec.jal ? '1 : (regrt ? rt : rd);
    end

    assign aluimm_d = dec.aluimm;
    assign shift_d  = dec.shift;

    // r0 is never a real destination, so it never creates a hazard.
    assign e_hit = e_q.wreg && (e_q.rn != '0) &&
                   ((use_rs && e_q.rn == rs) || (use_rt && e_q.rn == rt));

`ifdef PIPE_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r, input ectl_t e,
                                           input mctl_t m);
        if (e.wreg && e.rn != '0 && e.rn == r && !e.m2reg) return 2'b01;
        if (m.wreg && m.rn != '0 && m.rn == r) return m.m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    // Only a load in EX cannot be forwarded in time.
    assign stall = e_hit && e_q.m2reg;
    assign fwda  = fwd_sel(rs, e_q, m_q);
    assign fwdb  = fwd_sel(rt, e_q, m_q);
`else
    logic m_hit;
    assign m_hit = m_q.wreg && (m_q.rn != '0) &&
                   ((use_rs && m_q.rn == rs) || (use_rt && m_q.rn == rt));
    // Without forwarding, wait until the writer is in WB (write-before-read regfile).
    assign stall = e_hit || m_hit;
    assign fwda  = 2'b00;
    assign fwdb  = 2'b00;
`endif

    assign wpcir = ~stall;

    // PC source select; a stalled instruction must not redirect the PC.
    always_comb begin
        pcsource = 2'b00;
        if (!stall) begin
            if ((is_beq && rsrtequ) || (is_bne && !rsrtequ)) pcsource = 2'b01;
            else if (is_jr)                                   pcsource = 2'b10;
            else if (is_j)                                    pcsource = 2'b11;
        end
    end

    // Pipeline advance: a stall loads a bubble into EX, later stages move on.
    always_comb begin
        e_d   = stall ? '0 : dec;
        m_d   = {e_q.wreg, e_q.m2reg, e_q.wmem, e_q.rn};
        w_d   = {m_q.wreg, m_q.m2reg, m_q.rn};
        cnt_d = cnt_q;
        if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    // E/M/W control registers and stall counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign ewreg     = e_q.wreg;
    assign em2reg    = e_q.m2reg;
    assign ewmem     = e_q.wmem;
    assign ealuimm   = e_q.aluimm;
    assign eshift    = e_q.shift;
    assign ejal      = e_q.jal;
    assign ealuc     = e_q.aluc;
    assign ern       = e_q.rn;
    assign mwreg     = m_q.wreg;
    assign mm2reg    = m_q.m2reg;
    assign mwmem     = m_q.wmem;
    assign mrn       = m_q.rn;
    assign wwreg     = w_q.wreg;
    assign wm2reg    = w_q.m2reg;
    assign wrn       = w_q.rn;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Self-checking bench for pipe_ctrl_hazard: directed sequences plus random
// instruction streams, compared against an instruction-level pipeline model.
module tb_pipe_ctrl_hazard;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] inst;
    logic        rsrtequ;
    logic        wpcir, regrt, sext, aluimm_d, shift_d;
    logic [1:0]  pcsource, fwda, fwdb;
    logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic [3:0]  ealuc;
    logic [4:0]  ern, mrn, wrn;
    logic        mwreg, mm2reg, mwmem, wwreg, wm2reg;
    logic [15:0] stall_cnt;

    pipe_ctrl_hazard dut (
        .clock(clock), .resetn(resetn), .inst(inst), .rsrtequ(rsrtequ),
        .wpcir(wpcir), .pcsource(pcsource), .regrt(regrt), .sext(sext),
        .aluimm_d(aluimm_d), .shift_d(shift_d), .fwda(fwda), .fwdb(fwdb),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
        .eshift(eshift), .ejal(ejal), .ealuc(ealuc), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mrn(mrn),
        .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    localparam int ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, SLT = 5, SLL = 6, SRL = 7;
    localparam int SRA = 8, JR = 9, ADDI = 10, ANDI = 11, ORI = 12, XORI = 13, LW = 14;
    localparam int SW = 15, BEQ = 16, BNE = 17, LUI = 18, J = 19, JAL = 20, NOP = 21;

    // Per-mnemonic properties; br: 0 none, 1 beq, 2 bne, 3 jr, 4 j/jal.
    typedef struct packed {
        logic [5:0] opc;
        logic [5:0] fn;
        logic wreg, m2reg, wmem, aluimm, shift, jal, regrt, sext, urs, urt;
        logic [2:0] br;
        logic [3:0] aluc;
    } op_t;

    // In-flight instruction as seen by the model.
    typedef struct packed {
        logic wreg, m2reg, wmem, aluimm, shift, jal;
        logic [3:0] aluc;
        logic [4:0] rn;
    } st_t;

    st_t me, mm, mw;
    int  mcnt;
    int  errors = 0;
    int  checks = 0;

    function automatic op_t props(input int k);
        op_t p = '0;
        case (k)
            ADD:  begin p.fn = 6'h20; p.wreg = 1; p.urs = 1; p.urt = 1; end
            SUB:  begin p.fn = 6'h22; p.wreg = 1; p.urs = 1; p.urt = 1; p.aluc = 4'b0100; end
            AND:  begin p.fn = 6'h24; p.wreg = 1; p.urs = 1; p.urt = 1; p.aluc = 4'b0001; end
            OR:   begin p.fn = 6'h25; p.wreg = 1; p.urs = 1; p.urt = 1; p.aluc = 4'b0101; end
            XOR:  begin p.fn = 6'h26; p.wreg = 1; p.urs = 1; p.urt = 1; p.aluc = 4'b0010; end
            SLT:  begin p.fn = 6'h2a; p.wreg = 1; p.urs = 1; p.urt = 1; p.aluc = 4'b1000; end
            SLL:  begin p.fn = 6'h00; p.wreg = 1; p.shift = 1; p.urt = 1; p.aluc = 4'b0011; end
            SRL:  begin p.fn = 6'h02; p.wreg = 1; p.shift = 1; p.urt = 1; p.aluc = 4'b0111; end
            SRA:  begin p.fn = 6'h03; p.wreg = 1; p.shift = 1; p.urt = 1; p.aluc = 4'b1111; end
            JR:   begin p.fn = 6'h08; p.urs = 1; p.br = 3; end
            ADDI: begin p.opc = 6'h08; p.wreg = 1; p.aluimm = 1; p.regrt = 1; p.sext = 1; p.urs = 1; end
            ANDI: begin p.opc = 6'h0c; p.wreg = 1; p.aluimm = 1; p.regrt = 1; p.urs = 1; p.aluc = 4'b0001; end
            ORI:  begin p.opc = 6'h0d; p.wreg = 1; p.aluimm = 1; p.regrt = 1; p.urs = 1; p.aluc = 4'b0101; end
            XORI: begin p.opc = 6'h0e; p.wreg = 1; p.aluimm = 1; p.regrt = 1; p.urs = 1; p.aluc = 4'b0010; end
            LW:   begin
                p.opc = 6'h23; p.wreg = 1; p.m2reg = 1; p.aluimm = 1; p.regrt = 1; p.sext = 1; p.urs = 1;
            end
            SW:   begin p.opc = 6'h2b; p.wmem = 1; p.aluimm = 1; p.sext = 1; p.urs = 1; p.urt = 1; end
            BEQ:  begin p.opc = 6'h04; p.sext = 1; p.urs = 1; p.urt = 1; p.br = 1; p.aluc = 4'b0010; end
            BNE:  begin p.opc = 6'h05; p.sext = 1; p.urs = 1; p.urt = 1; p.br = 2; p.aluc = 4'b0010; end
            LUI:  begin p.opc = 6'h0f; p.wreg = 1; p.aluimm = 1; p.regrt = 1; p.aluc = 4'b0110; end
            J:    begin p.opc = 6'h02; p.br = 4; end
            JAL:  begin p.opc = 6'h03; p.wreg = 1; p.jal = 1; p.br = 4; end
            default: p.opc = 6'h3f;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] make(input int k, input logic [4:0] rs, rt, rd);
        op_t p = props(k);
        return {p.opc, rs, rt, rd, 5'd0, p.fn};
    endfunction

    function automatic logic hit(input st_t s, input logic [4:0] rs, rt, input logic urs, urt);
        return s.wreg && s.rn != 0 && ((urs && s.rn == rs) || (urt && s.rn == rt));
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] r);
        if (me.wreg && me.rn != 0 && me.rn == r && !me.m2reg) return 2'b01;
        if (mm.wreg && mm.rn != 0 && mm.rn == r) return mm.m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the model for the instruction now in ID.
    task automatic check_now(input int k, input logic [4:0] rs, rt, rd, input logic eq,
                             output logic stall, output st_t ide);
        op_t p = props(k);
        logic [1:0] fa, fb, pcs;
        ide = '0;
        ide.wreg = p.wreg; ide.m2reg = p.m2reg; ide.wmem = p.wmem; ide.aluimm = p.aluimm;
        ide.shift = p.shift; ide.jal = p.jal; ide.aluc = p.aluc;
        ide.rn = p.jal ? 5'd31 : (p.regrt ? rt : rd);
`ifdef PIPE_FWD_EN
        stall = hit(me, rs, rt, p.urs, p.urt) && me.m2reg;
        fa = fsel(rs);
        fb = fsel(rt);
`else
        stall = hit(me, rs, rt, p.urs, p.urt) || hit(mm, rs, rt, p.urs, p.urt);
        fa = 2'b00;
        fb = 2'b00;
`endif
        pcs = 2'b00;
        if (!stall) begin
            if ((p.br == 1 && eq) || (p.br == 2 && !eq)) pcs = 2'b01;
            else if (p.br == 3) pcs = 2'b10;
            else if (p.br == 4) pcs = 2'b11;
        end
        chk("wpcir", wpcir, !stall);
        chk("pcsource", pcsource, pcs);
        chk("regrt", regrt, p.regrt);
        chk("sext", sext, p.sext);
        chk("aluimm_d", aluimm_d, p.aluimm);
        chk("shift_d", shift_d, p.shift);
        chk("fwda", fwda, fa);
        chk("fwdb", fwdb, fb);
        chk("e_ctl", {ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc}, me[14:5]);
        chk("ern", ern, me.rn);
        chk("m_ctl", {mwreg, mm2reg, mwmem, mrn}, {mm.wreg, mm.m2reg, mm.wmem, mm.rn});
        chk("w_ctl", {wwreg, wm2reg, wrn}, {mw.wreg, mw.m2reg, mw.rn});
        chk("stall_cnt", stall_cnt, mcnt);
    endtask

    task automatic step(input int k, input logic [4:0] rs, rt, rd, input logic eq,
                        output logic stall);
        st_t ide;
        inst    = make(k, rs, rt, rd);
        rsrtequ = eq;
        @(negedge clock);
        check_now(k, rs, rt, rd, eq, stall, ide);
        @(posedge clock);
        mw = mm;
        mm = me;
        me = stall ? '0 : ide;
        if (stall && mcnt != 65535) mcnt++;
        #1;
    endtask

    // Hold the instruction in ID until the model says it may advance.
    task automatic issue(input int k, input logic [4:0] rs, rt, rd, input logic eq = 1'b0);
        logic st;
        int   n = 0;
        step(k, rs, rt, rd, eq, st);
        while (st && n < 3) begin
            step(k, rs, rt, rd, eq, st);
            n++;
        end
        if (st) chk("stall_bound", 32'd1, 32'd0);
    endtask

    initial begin
        logic st;
        st_t  ide;
        resetn  = 1'b0;
        inst    = make(NOP, 0, 0, 0);
        rsrtequ = 1'b0;
        me = '0; mm = '0; mw = '0; mcnt = 0;
        #2;
        check_now(NOP, 0, 0, 0, 0, st, ide);
        @(posedge clock);
        @(posedge clock);
        #1 resetn = 1'b1;

        // ALU-to-ALU dependences at distance 1 and 2.
        issue(ADD, 1, 2, 3);
        issue(SUB, 3, 1, 4);
        issue(OR, 3, 0, 5);
        repeat (3) issue(NOP, 0, 0, 0);

        // Load-use pair.
        issue(LW, 1, 3, 0);
        issue(ADD, 3, 2, 4);
        repeat (3) issue(NOP, 0, 0, 0);

        // Branches and jumps, including the jal link register.
        issue(BEQ, 1, 1, 0, 1'b1);
        issue(BNE, 1, 1, 0, 1'b1);
        issue(BNE, 1, 2, 0, 1'b0);
        issue(JAL, 0, 0, 0);
        issue(JR, 31, 0, 0);
        issue(J, 0, 0, 0);

        // Writes to r0 never forward or stall.
        issue(ADDI, 1, 0, 0);
        issue(ADD, 0, 0, 2);
        issue(SW, 2, 2, 0);
        repeat (3) issue(NOP, 0, 0, 0);

        // Reset asserted in the middle of a stall.
        step(LW, 1, 3, 0, 0, st);
        step(ADD, 3, 2, 4, 0, st);
        resetn = 1'b0;
        #2;
        me = '0; mm = '0; mw = '0; mcnt = 0;
        check_now(ADD, 3, 2, 4, 0, st, ide);
        @(posedge clock);
        #1 resetn = 1'b1;
        issue(ADD, 3, 2, 4);

        // Random streams over a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 21), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_hazard.md
Name: pipe_ctrl_hazard

Overview:
- Next-generation pipeline control unit for the 5-stage MIPS32 core.
- Decodes the ID-stage instruction and owns the control bits of the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects RAW hazards and drives operand-forwarding selects, load-use stalls and bubble insertion. It also counts stall cycles.
- Branches and jumps resolve in ID with one delay slot. There is no flush.

Parameters:
- RA_W, 5: register-address width. The link register for jal is all-ones (r31 at default).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- inst  in  32  ID-stage instruction word
- rsrtequ  in  1  ID-stage compare result: forwarded rs == forwarded rt
- wpcir  out  1  PC/IF-ID write enable; 0 = stall
- pcsource  out  2  00 pc+4, 01 branch, 10 jr, 11 j/jal
- regrt, sext, aluimm_d, shift_d  out  1 each  ID-stage decode
- fwda, fwdb  out  2 each  operand select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM mem data
- ewreg, em2reg, ewmem, ealuimm, eshift, ejal  out  1 each  EX-stage control
- ealuc  out  4  EX-stage ALU op
- ern  out  RA_W  EX-stage destination register
- mwreg, mm2reg, mwmem  out  1 each  MEM-stage control
- mrn  out  RA_W  MEM-stage destination register
- wwreg, wm2reg  out  1 each  WB-stage control
- wrn  out  RA_W  WB-stage destination register
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: when resetn is low (asynchronous), every E/M/W register clears to 0, as does stall_cnt.
- Decoded set: add, sub, and, or, xor, slt, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. Any other encoding behaves as a NOP: no writes, pcsource 00.
- ALU op codes (ealuc):
  - add/addi/lw/sw 0000, sub 0100, and/andi 0001, or/ori 0101
  - xor/xori/beq/bne 0010, lui 0110, sll 0011, srl 0111, sra 1111, slt 1000
- Destination: drn = jal ? all-ones : (regrt ? rt : rd).
- regrt is set for addi, andi, ori, xori, lw, lui.
- pcsource: 01 when (beq & rsrtequ) | (bne & ~rsrtequ); 10 for jr; 11 for j or jal. Otherwise 00.
- Source usage:
  - use_rs: every op except sll, srl, sra, lui, j, jal.
  - use_rt: R-type ALU ops, shifts, sw, beq, bne.
- Forwarding (per operand, rs shown; rt identical). The first matching rule wins:
  - ewreg & ern!=0 & ern==rs & ~em2reg -> 01
  - else mwreg & mrn!=0 & mrn==rs -> mm2reg ? 11 : 10
  - else 00
- Load-use stall = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
  - On stall: wpcir=0. The E stage loads a bubble: ewreg, ewmem, em2reg and ejal are 0, ern is 0. M and W advance normally. pcsource is forced to 00.
  - A stall lasts exactly one cycle per load-use pair.
- Pipeline advance: on every posedge, D->E, E->M and M->W control registers shift. ewmem is only set for sw. Writes to r0 never forward or stall.
- Register file is write-before-read, so a WB-stage writer needs no forwarding.
- stall_cnt increments on each stall cycle and saturates at 2^CNT_W-1.
- If resetn asserts mid-stall, the stall is abandoned. After release the pipeline restarts empty with wpcir=1.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined: forwarding as above.
- Undefined: fwda and fwdb are tied to 00. The stall condition becomes any nonzero-rn match for a used source against an EX writer (ewreg) or a MEM writer (mwreg). The hazard stalls until the writer reaches WB (up to 2 cycles). stall_cnt counts every such cycle.

Test Plan:
- Reset: hold resetn=0, then release -> all E/M/W outputs 0, stall_cnt=0, wpcir=1.
- add $3,$1,$2 then sub $4,$3,$1 -> on sub in ID, fwda=01. One cycle later a dependent or $5,$3,$0 gets fwda=10.
- lw $3,0($1) then add $4,$3,$2 -> one cycle with wpcir=0 and bubble in E (ewreg=0), then fwda=11; stall_cnt=1.
- beq $1,$1 with rsrtequ=1 -> pcsource=01. jal -> pcsource=11 and the E-stage ern becomes 31.
- addi $0,$1,5 then add $2,$0,$0 -> fwda=fwdb=00, no stall.
- PIPE_FWD_EN undefined, add $3 then dependent sub on $3 -> two stall cycles, stall_cnt=2, then fwda=00.
